// File: rtl/mem_arbiter.sv
// N-port cacheline arbiter in front of physical memory: one granted transaction at a time, registered commands.
// Define ARBITER_FIXED_PRIO_EN for lowest-index-wins priority; default build is round-robin.
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int s_offset  = 4,
  parameter int size      = (2**s_offset)*8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PORTS*32-1:0]   req_address,
  input  logic [NUM_PORTS-1:0]      req_read,
  input  logic [NUM_PORTS-1:0]      req_write,
  input  logic [NUM_PORTS*size-1:0] req_wdata,
  output logic [size-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]      req_resp,
  input  logic [size-1:0]           pmem_rdata_c,
  input  logic                      pmem_resp_c,
  output logic [31:0]               pmem_address_c,
  output logic                      pmem_read_c,
  output logic                      pmem_write_c,
  output logic [size-1:0]           pmem_wdata_c
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 r_state, w_state_next;
  logic [PW-1:0]          r_grant;
  logic [PW-1:0]          w_winner;
  logic                   w_any;
  logic [NUM_PORTS-1:0]   w_pending;
  logic [31:0]            r_pmem_address;
  logic                   r_pmem_read;
  logic                   r_pmem_write;
  logic [size-1:0]        r_pmem_wdata;
  logic [size-1:0]        r_rdata;
  logic [NUM_PORTS-1:0]   r_resp;

  assign w_pending = req_read | req_write;

`ifdef ARBITER_FIXED_PRIO_EN
  // Scan downward so the lowest pending index is the last one written.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      if (w_pending[PW'(i)]) begin
        w_winner = PW'(i);
        w_any    = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] r_ptr;
  logic [PW:0]   w_sum;

  // Scan offsets downward from the pointer so the nearest pending port wins.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    w_sum    = '0;
    for (int off = NUM_PORTS-1; off >= 0; off--) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(off);
      if (w_sum >= (PW+1)'(NUM_PORTS)) w_sum = w_sum - (PW+1)'(NUM_PORTS);
      if (w_pending[w_sum[PW-1:0]]) begin
        w_winner = w_sum[PW-1:0];
        w_any    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (r_state == RESP) begin
      r_ptr <= (r_grant == PW'(NUM_PORTS-1)) ? '0 : r_grant + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = BUSY;
      BUSY:    if (pmem_resp_c) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant        <= '0;
      r_pmem_address <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_wdata   <= '0;
      r_rdata        <= '0;
      r_resp         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant        <= w_winner;
            r_pmem_address <= req_address[w_winner*32 +: 32];
            r_pmem_wdata   <= req_wdata[w_winner*size +: size];
            r_pmem_write   <= req_write[w_winner];
            r_pmem_read    <= ~req_write[w_winner];
          end
        end
        BUSY: begin
          if (pmem_resp_c) begin
            // rdata is only replaced by reads; after a write the old line stays visible.
            if (r_pmem_read) r_rdata <= pmem_rdata_c;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_resp         <= NUM_PORTS'(1) << r_grant;
          end
        end
        default: r_resp <= '0;
      endcase
    end
  end

  assign pmem_address_c = r_pmem_address;
  assign pmem_read_c    = r_pmem_read;
  assign pmem_write_c   = r_pmem_write;
  assign pmem_wdata_c   = r_pmem_wdata;
  assign req_resp       = r_resp;
  assign req_rdata      = (r_state == RESP) ? r_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: 2-port instance driven by hand, 4-port instance with a 1-cycle responder.
module tb_mem_arbiter;

`ifdef ARBITER_FIXED_PRIO_EN
  localparam logic FIXED = 1'b1;
`else
  localparam logic FIXED = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [63:0]  req_address;
  logic [1:0]   req_read, req_write;
  logic [255:0] req_wdata;
  logic [127:0] req_rdata;
  logic [1:0]   req_resp;
  logic [127:0] pmem_rdata_c;
  logic         pmem_resp_c;
  logic [31:0]  pmem_address_c;
  logic         pmem_read_c, pmem_write_c;
  logic [127:0] pmem_wdata_c;

  logic [127:0] req_address4;
  logic [3:0]   req_read4, req_write4;
  logic [511:0] req_wdata4;
  logic [127:0] req_rdata4;
  logic [3:0]   req_resp4;
  logic [127:0] pmem_rdata4;
  logic         pmem_resp4;
  logic [31:0]  pmem_address4;
  logic         pmem_read4, pmem_write4;
  logic [127:0] pmem_wdata4;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] LA5 = {16{8'hA5}};
  localparam logic [127:0] W12 = {8{16'h1234}};
  localparam logic [127:0] LC3 = {16{8'hC3}};

  mem_arbiter #(.NUM_PORTS(2), .s_offset(4)) u_dut (
    .clk(clk), .rst(rst),
    .req_address(req_address), .req_read(req_read), .req_write(req_write),
    .req_wdata(req_wdata), .req_rdata(req_rdata), .req_resp(req_resp),
    .pmem_rdata_c(pmem_rdata_c), .pmem_resp_c(pmem_resp_c),
    .pmem_address_c(pmem_address_c), .pmem_read_c(pmem_read_c),
    .pmem_write_c(pmem_write_c), .pmem_wdata_c(pmem_wdata_c)
  );

  mem_arbiter #(.NUM_PORTS(4), .s_offset(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_address(req_address4), .req_read(req_read4), .req_write(req_write4),
    .req_wdata(req_wdata4), .req_rdata(req_rdata4), .req_resp(req_resp4),
    .pmem_rdata_c(pmem_rdata4), .pmem_resp_c(pmem_resp4),
    .pmem_address_c(pmem_address4), .pmem_read_c(pmem_read4),
    .pmem_write_c(pmem_write4), .pmem_wdata_c(pmem_wdata4)
  );

  // 4-port instance talks to a memory that answers in the first BUSY cycle.
  assign pmem_resp4  = pmem_read4 | pmem_write4;
  assign pmem_rdata4 = LC3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the IDLE negedge after requests are set; returns at the RESP negedge.
  // mode 1 drops all requests in the first BUSY cycle, mode 2 raises a port-1 write there.
  task automatic serve(input string tag, input int lat, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [127:0] wd, input logic [127:0] rline,
                       input logic [127:0] exp_rdata, input int mode, input logic [1:0] exp_resp);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk({tag, "_rd"}, pmem_read_c, rd);
      chk({tag, "_wr"}, pmem_write_c, wr);
      chk({tag, "_addr"}, pmem_address_c, addr);
      if (wr) chk({tag, "_wdata"}, pmem_wdata_c, wd);
      if (i == 1 && mode == 1) begin
        req_read  = '0;
        req_write = '0;
      end
      if (i == 1 && mode == 2) begin
        req_write[1]        = 1'b1;
        req_address[63:32]  = 32'h0000_2000;
        req_wdata[255:128]  = W12;
      end
      if (i == lat) begin
        pmem_resp_c  = 1'b1;
        pmem_rdata_c = rline;
      end
    end
    @(negedge clk);
    pmem_resp_c  = 1'b0;
    pmem_rdata_c = '0;
    chk({tag, "_resp"}, req_resp, exp_resp);
    chk({tag, "_rdata"}, req_rdata, exp_rdata);
    chk({tag, "_rd_off"}, pmem_read_c, 1'b0);
    chk({tag, "_wr_off"}, pmem_write_c, 1'b0);
    $display("[TB] %s: resp=%b rdata=%h", tag, req_resp, req_rdata);
  endtask

  task automatic wait_resp4(output logic [3:0] r);
    r = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_resp4 != 4'b0) begin
        r = req_resp4;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] r4;
    logic [1:0] g;
    rst = 1'b0;
    req_address = '0; req_read = '0; req_write = '0; req_wdata = '0;
    pmem_rdata_c = '0; pmem_resp_c = 1'b0;
    req_address4 = '0; req_read4 = '0; req_write4 = '0; req_wdata4 = '0;

    // Reset state
    #1;
    chk("rst_rd", pmem_read_c, 1'b0);
    chk("rst_wr", pmem_write_c, 1'b0);
    chk("rst_addr", pmem_address_c, 32'h0);
    chk("rst_wdata", pmem_wdata_c, 128'h0);
    chk("rst_resp", req_resp, 2'b00);
    chk("rst_rdata", req_rdata, 128'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single read on port 1, memory answers in cycle 4
    req_read = 2'b10;
    req_address[63:32] = 32'h0000_1040;
    chk("t1_c0_rd", pmem_read_c, 1'b0);
    serve("t1", 4, 1'b1, 1'b0, 32'h0000_1040, '0, LA5, LA5, 0, 2'b10);
    @(negedge clk);
    req_read = '0;
    chk("t1_c6_resp", req_resp, 2'b00);
    chk("t1_c6_rdata", req_rdata, 128'h0);
    @(negedge clk);
    chk("t1_c7_rd", pmem_read_c, 1'b0);

    // Both ports reading continuously
    req_read = 2'b11;
    req_address = {32'h0000_0180, 32'h0000_0100};
    for (int t = 0; t < 4; t++) begin
      if (t > 0) @(negedge clk);
      g = FIXED ? 2'd0 : 2'(t % 2);
      serve($sformatf("t2_%0d", t), 1, 1'b1, 1'b0, (g == 2'd0) ? 32'h100 : 32'h180, '0,
            {4{32'h0BAD_0000 + 32'(t)}}, {4{32'h0BAD_0000 + 32'(t)}}, 0, 2'b01 << g);
    end

    // Port 0 read in BUSY while port 1 raises a write
    @(negedge clk);
    req_read = 2'b01;
    req_write = '0;
    req_address = {32'h0, 32'h0000_3000};
    req_wdata = '0;
    serve("t3a", 3, 1'b1, 1'b0, 32'h0000_3000, '0, {4{32'h3333_0000}}, {4{32'h3333_0000}}, 2, 2'b01);
    @(negedge clk);
    req_read[0] = 1'b0;
    serve("t3b", 2, 1'b0, 1'b1, 32'h0000_2000, W12, {4{32'hDEAD_BEEF}}, {4{32'h3333_0000}}, 0, 2'b10);
    @(negedge clk);
    req_write = '0;

    // Port 0 drops its request during BUSY
    req_read = 2'b01;
    req_address = {32'h0, 32'h0000_4000};
    serve("t4", 3, 1'b1, 1'b0, 32'h0000_4000, '0, {4{32'h4444_0000}}, {4{32'h4444_0000}}, 1, 2'b01);
    @(negedge clk);
    chk("t4_idle_rd", pmem_read_c, 1'b0);

    // Reset asserted in BUSY
    req_read = 2'b01;
    req_address = {32'h0, 32'h0000_5000};
    @(negedge clk);
    chk("t5_busy_rd", pmem_read_c, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_rd", pmem_read_c, 1'b0);
    chk("t5_async_addr", pmem_address_c, 32'h0);
    chk("t5_async_resp", req_resp, 2'b00);
    chk("t5_async_rdata", req_rdata, 128'h0);
    req_read = '0;
    @(negedge clk);
    rst = 1'b1;
    // Both pending right after release: pointer back at 0 means port 0 wins
    req_read = 2'b11;
    req_address = {32'h0000_6000, 32'h0000_5000};
    serve("t5a", 1, 1'b1, 1'b0, 32'h0000_5000, '0, {4{32'h5555_0000}}, {4{32'h5555_0000}}, 1, 2'b01);
    @(negedge clk);
    req_read = 2'b10;
    serve("t5b", 1, 1'b1, 1'b0, 32'h0000_6000, '0, {4{32'h6666_0000}}, {4{32'h6666_0000}}, 1, 2'b10);
    @(negedge clk);

    // 4-port instance: port 1 first moves the pointer to 2, then ports 1 and 3 compete
    req_read4 = 4'b0010;
    req_address4[63:32] = 32'h0000_7010;
    req_address4[127:96] = 32'h0000_7030;
    wait_resp4(r4);
    chk("t6_first", r4, 4'b0010);
    chk("t6_rdata", req_rdata4, LC3);
    $display("[TB] t6_first: resp=%b", r4);
    @(negedge clk);
    req_read4 = 4'b1010;
    wait_resp4(r4);
    chk("t6_second", r4, FIXED ? 4'b0010 : 4'b1000);
    $display("[TB] t6_second: resp=%b", r4);
    @(negedge clk);
    req_read4 = FIXED ? 4'b1000 : 4'b0010;
    wait_resp4(r4);
    chk("t6_third", r4, FIXED ? 4'b1000 : 4'b0010);
    $display("[TB] t6_third: resp=%b", r4);
    @(negedge clk);
    req_read4 = '0;
    @(negedge clk);
    chk("t6_idle_rd", pmem_read4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-port arbiter between the cache hierarchy and physical memory, replacing the fixed two-port instruction/data mux. It accepts cacheline read/write requests from NUM_PORTS requesters, grants one per memory transaction under round-robin (or fixed) priority, and locks the grant until memory responds. Commands to memory are registered, and responses are returned to the winning requester through a registered one-cycle pulse.

## Interface
- NUM_PORTS, 2, number of requesters (2..8); port 0 is the I-cache and port 1 the D-cache in the default build.
- s_offset, 4, log2 of cacheline bytes.
- size, (2**s_offset)*8, cacheline width in bits.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_address  in  NUM_PORTS×32  per-port line address.
- req_read  in  NUM_PORTS  per-port read request, level, held until that port's req_resp.
- req_write  in  NUM_PORTS  per-port write request, level, held until that port's req_resp.
- req_wdata  in  NUM_PORTS×size  per-port write line.
- req_rdata  out  size  shared read-data bus, valid only in the cycle some req_resp bit is high.
- req_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse to the granted port.
- pmem_rdata_c  in  size  memory read line.
- pmem_resp_c  in  1  memory completion, one cycle.
- pmem_address_c  out  32  registered memory address.
- pmem_read_c  out  1  registered memory read.
- pmem_write_c  out  1  registered memory write.
- pmem_wdata_c  out  size  registered memory write line.

## Operation
- FSM has three states: IDLE, BUSY and RESP.
- IDLE:
  - The arbiter evaluates `pending[i] = req_read[i] | req_write[i]`.
  - If any port is pending, it selects a winner and latches grant index, address, wdata and op (write if req_write, else read) at the edge, then moves to BUSY.
  - If no port is pending, it stays in IDLE.
- BUSY:
  - pmem_read_c/pmem_write_c are driven from the latched op, and pmem_address_c/pmem_wdata_c from the latched values.
  - Requester inputs are ignored.
  - On pmem_resp_c, the arbiter latches pmem_rdata_c (read ops only) and moves to RESP.
- RESP:
  - req_resp[grant] = 1 and req_rdata = the latched line; all pmem command outputs are 0.
  - The round-robin pointer updates to grant+1 (mod NUM_PORTS).
  - Next state is always IDLE.
- Round-robin selection: the first pending port scanning from the pointer upward, wrapping modulo NUM_PORTS. Pointer reset value is 0.
- If req_read and req_write are both high on one port, the op is treated as a write.
- If a requester drops its request during BUSY, the memory transaction still completes and the resp pulse is still issued.
- req_rdata is 0 outside RESP. In RESP after a write op it holds the previous read value; requesters must ignore it.

## Timing
- Reset (async assert, sync deassert by the surrounding design) puts the block in IDLE with pointer=0, grant=0, and all outputs 0: pmem_read_c, pmem_write_c, pmem_address_c, pmem_wdata_c, req_resp and req_rdata.
- Reset during BUSY abandons the transaction; memory is reset by the same rst.
- Request visible in cycle 0 → pmem command high from cycle 1 through the cycle pmem_resp_c is sampled high (cycle k) → req_resp in cycle k+1 → IDLE in cycle k+2.
- Minimum occupancy with 1-cycle memory is 3 cycles per transaction (IDLE, BUSY, RESP).
- A requester sees resp in cycle k+1 and changes its outputs from cycle k+2. The arbiter re-samples in that cycle, so there is no double grant.
- The pmem command is stable for the whole of BUSY; there are no glitches between transactions, and at least one command-free cycle (RESP) separates them.

## Configuration
- ARBITER_FIXED_PRIO_EN defined:
  - The lowest-index pending port always wins (port 0 highest), matching instruction-fetch-first priority.
  - The pointer register is not instantiated.
- ARBITER_FIXED_PRIO_EN undefined: round-robin as described above (default).

## Test plan
- Single read, port 1, address 0x0000_1040, memory resp after 4 cycles with line 0xA5..A5:
  - pmem_read_c=1 with address 0x1040 for cycles 1–4.
  - req_resp=2'b10 and req_rdata=0xA5..A5 in cycle 5.
  - IDLE in cycle 6.
- Ports 0 and 1 both reading continuously, round-robin build: grants alternate 0,1,0,1 over four transactions. With ARBITER_FIXED_PRIO_EN, all four grants go to port 0.
- Write on port 1 (address 0x2000, wdata 0x1234..) while port 0 has been granted and is in BUSY:
  - The port-0 transaction completes untouched.
  - The next grant is port 1, with pmem_write_c=1 and pmem_wdata_c=0x1234.. latched.
- Port 0 request dropped mid-BUSY: memory still receives the full command until pmem_resp_c, and req_resp[0] still pulses.
- rst low in BUSY: all outputs are 0 in the same cycle (async), and after release the state is IDLE with pointer 0. An immediate port-1 request is granted.
- NUM_PORTS=4, ports 1 and 3 pending with pointer=2: port 3 wins, then the pointer moves to 0, and the next grant is port 1.
